// File: rtl/configure_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package configure;

    // BRAM depth in 32-bit words; address wrap is applied inside the bram block.
    localparam int bram_depth = 1024;

    // Owner encoding carried in the response tag.
    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

    // One memory access as presented by a core port.
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // Tag travelling alongside an issued access until its response returns.
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/bram_req_slot.sv
// One-entry pending slot for a single core port. The slot is transparent:
// a request being loaded this cycle is already visible at `head`, so the
// arbiter can issue it at the same edge it would otherwise be captured.
module bram_req_slot
    import configure::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,   // accept req this cycle (slot must be empty)
    input  logic     clear,  // head is granted this cycle
    input  mem_req_t req,
    output logic     avail,  // slot holds a request, or one is arriving now
    output mem_req_t head    // request the arbiter would issue
);

    logic     full;
    mem_req_t held;

    assign avail = full | load;
    assign head  = full ? held : req;

    // Full flag: set when a request is captured and not granted in the same edge.
    always_ff @(posedge clk) begin
        if (rst) full <= 1'b0;
        else     full <= avail & ~clear;
    end

    // Payload register; only meaningful while full is set.
    always_ff @(posedge clk) begin
        if (load) held <= req;
    end

endmodule

// File: rtl/bram_arbiter.sv
// Serialises the core's instruction and data ports onto the single BRAM port.
// Each accepted request is issued on registered bram_* outputs, tagged with
// its owner, and the BRAM response one cycle later is routed back by tag.
module bram_arbiter
    import configure::*;
#(
    parameter bit FAIR = 1'b1  // 1: round-robin on contention, 0: dmem always wins
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    // A port is busy from capture until its ready pulse; a valid seen while
    // busy breaks the one-outstanding protocol and is dropped. A new valid in
    // the same cycle as ready is legal, since the previous access is done.
    logic imem_busy, dmem_busy;
    logic imem_accept, dmem_accept;

    assign imem_accept = imem_valid & (~imem_busy | imem_ready);
    assign dmem_accept = dmem_valid & (~dmem_busy | dmem_ready);

    mem_req_t imem_req, dmem_req;
    mem_req_t imem_head, dmem_head, grant_req;
    logic     imem_avail, dmem_avail;
    logic     grant_imem, grant_dmem, grant_any;
    logic     rr, rr_next;   // owner granted last on contention
    tag_t     tag_issue;     // aligned with bram_valid
    tag_t     tag_resp;      // aligned with bram_ready

    assign imem_req = '{instr: imem_instr, addr: imem_addr, wdata: imem_wdata, wstrb: imem_wstrb};
    assign dmem_req = '{instr: dmem_instr, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

    bram_req_slot u_imem_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (imem_accept),
        .clear (grant_imem),
        .req   (imem_req),
        .avail (imem_avail),
        .head  (imem_head)
    );

    bram_req_slot u_dmem_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (dmem_accept),
        .clear (grant_dmem),
        .req   (dmem_req),
        .avail (dmem_avail),
        .head  (dmem_head)
    );

    // Grant selection. The rr pointer only moves when both ports compete, so
    // back-to-back collisions alternate which port goes first.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        rr_next    = rr;
        if (imem_avail && dmem_avail) begin
            if (FAIR) begin
                if (rr == OWNER_DMEM) begin
                    grant_imem = 1'b1;
                    rr_next    = OWNER_IMEM;
                end else begin
                    grant_dmem = 1'b1;
                    rr_next    = OWNER_DMEM;
                end
            end else begin
                grant_dmem = 1'b1;
            end
        end else if (imem_avail) begin
            grant_imem = 1'b1;
        end else if (dmem_avail) begin
            grant_dmem = 1'b1;
        end
    end

    assign grant_any = grant_imem | grant_dmem;
    assign grant_req = grant_dmem ? dmem_head : imem_head;

    // Control state: strobe, tag pipe, rr pointer and per-port busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_valid <= 1'b0;
            bram_wstrb <= 4'b0;
            tag_issue  <= '0;
            tag_resp   <= '0;
            rr         <= OWNER_DMEM;
            imem_busy  <= 1'b0;
            dmem_busy  <= 1'b0;
        end else begin
            bram_valid <= grant_any;
            if (grant_any) bram_wstrb <= grant_req.wstrb;
            tag_issue  <= '{valid: grant_any, owner: grant_dmem ? OWNER_DMEM : OWNER_IMEM};
            tag_resp   <= tag_issue;
            rr         <= rr_next;
            imem_busy  <= imem_accept | (imem_busy & ~imem_ready);
            dmem_busy  <= dmem_accept | (dmem_busy & ~dmem_ready);
        end
    end

    // Access payload; qualified by bram_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            bram_instr <= grant_req.instr;
            bram_addr  <= grant_req.addr;
            bram_wdata <= grant_req.wdata;
        end
    end

    // Response routing by tag; the non-owning port never sees ready.
    assign imem_ready = bram_ready & tag_resp.valid & (tag_resp.owner == OWNER_IMEM);
    assign dmem_ready = bram_ready & tag_resp.valid & (tag_resp.owner == OWNER_DMEM);
    assign imem_rdata = bram_rdata;
    assign dmem_rdata = bram_rdata;

    // Flag a port re-pulsing valid before its previous access completed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_valid && imem_busy && !imem_ready))
                else $warning("bram_arbiter: imem_valid while access outstanding, pulse dropped");
            assert (!(dmem_valid && dmem_busy && !dmem_ready))
                else $warning("bram_arbiter: dmem_valid while access outstanding, pulse dropped");
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench: a FAIR=1 arbiter and a FAIR=0 arbiter share the same core
// stimulus, each backed by its own one-cycle BRAM model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid, imem_instr, dmem_valid, dmem_instr;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic [3:0]  imem_wstrb, dmem_wstrb;

    logic [31:0] imem_rdata, dmem_rdata, bram_addr, bram_wdata, bram_rdata;
    logic        imem_ready, dmem_ready, bram_valid, bram_instr, bram_ready;
    logic [3:0]  bram_wstrb;

    logic [31:0] f0_imem_rdata, f0_dmem_rdata, f0_bram_addr, f0_bram_wdata, f0_bram_rdata;
    logic        f0_imem_ready, f0_dmem_ready, f0_bram_valid, f0_bram_instr, f0_bram_ready;
    logic [3:0]  f0_bram_wstrb;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    always #5 clk = ~clk;

    bram_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .bram_valid(bram_valid), .bram_instr(bram_instr), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata), .bram_ready(bram_ready)
    );

    bram_arbiter #(.FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(f0_imem_rdata), .imem_ready(f0_imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(f0_dmem_rdata), .dmem_ready(f0_dmem_ready),
        .bram_valid(f0_bram_valid), .bram_instr(f0_bram_instr), .bram_addr(f0_bram_addr),
        .bram_wdata(f0_bram_wdata), .bram_wstrb(f0_bram_wstrb), .bram_rdata(f0_bram_rdata), .bram_ready(f0_bram_ready)
    );

    // BRAM models: read-old-data, byte strobes, ready one cycle after valid.
    // Reset refills the pattern word[n] = 0x1111_0000 | n.
    always @(posedge clk) begin
        bram_ready <= bram_valid;
        if (bram_valid) bram_rdata <= mem_a[bram_addr[9:2]];
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'h1111_0000 | i;
        end else if (bram_valid) begin
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) mem_a[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        f0_bram_ready <= f0_bram_valid;
        if (f0_bram_valid) f0_bram_rdata <= mem_b[f0_bram_addr[9:2]];
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'h1111_0000 | i;
        end else if (f0_bram_valid) begin
            for (int b = 0; b < 4; b++)
                if (f0_bram_wstrb[b]) mem_b[f0_bram_addr[9:2]][8*b +: 8] <= f0_bram_wdata[8*b +: 8];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_imem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = a; imem_wdata = wd; imem_wstrb = ws;
    endtask

    task automatic drive_dmem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws;
    endtask

    task automatic idle;
        imem_valid = 1'b0; dmem_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; idle();
        tick(); tick();
        vectors++; if (bram_valid !== 1'b0) begin errors++; $display("FAIL rst_bram_valid got %b want 0", bram_valid); end
        vectors++; if (bram_wstrb !== 4'b0) begin errors++; $display("FAIL rst_bram_wstrb got %h want 0", bram_wstrb); end
        vectors++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL rst_imem_ready got %b want 0", imem_ready); end
        vectors++; if (dmem_ready !== 1'b0) begin errors++; $display("FAIL rst_dmem_ready got %b want 0", dmem_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        drive_imem(32'h10, 32'h0, 4'b0);
        tick(); idle();
        vectors++; if (bram_valid !== 1'b1) begin errors++; $display("FAIL rd_bram_valid got %b want 1", bram_valid); end
        vectors++; if (bram_addr !== 32'h10) begin errors++; $display("FAIL rd_bram_addr got %h want 00000010", bram_addr); end
        vectors++; if (bram_instr !== 1'b1) begin errors++; $display("FAIL rd_bram_instr got %b want 1", bram_instr); end
        tick();
        vectors++; if (imem_ready !== 1'b1) begin errors++; $display("FAIL rd_imem_ready got %b want 1", imem_ready); end
        vectors++; if (imem_rdata !== 32'h1111_0004) begin errors++; $display("FAIL rd_imem_rdata got %h want 11110004", imem_rdata); end
        vectors++; if (dmem_ready !== 1'b0) begin errors++; $display("FAIL rd_dmem_ready got %b want 0", dmem_ready); end
        tick();
        vectors++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse got %b want 0", imem_ready); end
    endtask

    task automatic test_byte_write;
        drive_dmem(32'h8, 32'hAABB_CCDD, 4'b0010);
        tick(); idle();
        vectors++; if (bram_wstrb !== 4'b0010) begin errors++; $display("FAIL wr_bram_wstrb got %h want 2", bram_wstrb); end
        vectors++; if (bram_wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_bram_wdata got %h want aabbccdd", bram_wdata); end
        tick();
        vectors++; if (dmem_ready !== 1'b1) begin errors++; $display("FAIL wr_dmem_ready got %b want 1", dmem_ready); end
        vectors++; if (dmem_rdata !== 32'h1111_0002) begin errors++; $display("FAIL wr_old_word got %h want 11110002", dmem_rdata); end
        vectors++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL wr_imem_ready got %b want 0", imem_ready); end
        drive_dmem(32'h8, 32'h0, 4'b0);
        tick(); idle();
        vectors++; if (bram_wstrb !== 4'b0) begin errors++; $display("FAIL rb_bram_wstrb got %h want 0", bram_wstrb); end
        tick();
        vectors++; if (dmem_ready !== 1'b1) begin errors++; $display("FAIL rb_dmem_ready got %b want 1", dmem_ready); end
        vectors++; if (dmem_rdata !== 32'h1111_CC02) begin errors++; $display("FAIL rb_rdata got %h want 1111cc02", dmem_rdata); end
        tick();
    endtask

    task automatic test_collision_fair;
        // rr = dmem: imem first; then the rr pointer favours dmem on the repeat.
        for (int k = 0; k < 2; k++) begin
            logic [31:0] first_addr, second_addr;
            first_addr  = (k == 0) ? 32'h10 : 32'h14;
            second_addr = (k == 0) ? 32'h14 : 32'h10;
            drive_imem(32'h10, 32'h0, 4'b0);
            drive_dmem(32'h14, 32'h0, 4'b0);
            tick(); idle();
            vectors++; if (bram_addr !== first_addr) begin errors++; $display("FAIL col%0d_first_addr got %h want %h", k, bram_addr, first_addr); end
            tick();
            vectors++; if (bram_valid !== 1'b1 || bram_addr !== second_addr) begin errors++; $display("FAIL col%0d_second_addr got %b/%h want 1/%h", k, bram_valid, bram_addr, second_addr); end
            vectors++; if (imem_ready !== (k == 0) || dmem_ready !== (k == 1)) begin errors++; $display("FAIL col%0d_ready_t2 got i%b d%b want i%0d d%0d", k, imem_ready, dmem_ready, k == 0, k == 1); end
            vectors++; if (bram_rdata !== ((k == 0) ? 32'h1111_0004 : 32'h1111_0005)) begin errors++; $display("FAIL col%0d_rdata_t2 got %h", k, bram_rdata); end
            tick();
            vectors++; if (imem_ready !== (k == 1) || dmem_ready !== (k == 0)) begin errors++; $display("FAIL col%0d_ready_t3 got i%b d%b want i%0d d%0d", k, imem_ready, dmem_ready, k == 1, k == 0); end
            tick();
        end
    endtask

    task automatic test_fixed_priority;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ia, da;
            ia = 32'h40 + 32'(k) * 8;
            da = ia + 32'h4;
            drive_imem(ia, 32'h0, 4'b0);
            drive_dmem(da, 32'h0, 4'b0);
            tick(); idle();
            vectors++; if (f0_bram_addr !== da || f0_bram_instr !== 1'b0) begin errors++; $display("FAIL fix%0d_first got %h/%b want %h/0", k, f0_bram_addr, f0_bram_instr, da); end
            tick();
            vectors++; if (f0_dmem_ready !== 1'b1 || f0_dmem_rdata !== (32'h1111_0000 | (da >> 2))) begin errors++; $display("FAIL fix%0d_dmem got %b/%h", k, f0_dmem_ready, f0_dmem_rdata); end
            vectors++; if (f0_bram_addr !== ia) begin errors++; $display("FAIL fix%0d_second got %h want %h", k, f0_bram_addr, ia); end
            tick();
            vectors++; if (f0_imem_ready !== 1'b1 || f0_imem_rdata !== (32'h1111_0000 | (ia >> 2))) begin errors++; $display("FAIL fix%0d_imem got %b/%h", k, f0_imem_ready, f0_imem_rdata); end
            vectors++; if (f0_dmem_ready !== 1'b0) begin errors++; $display("FAIL fix%0d_dmem_extra got %b want 0", k, f0_dmem_ready); end
            tick();
        end
    endtask

    task automatic test_reset_midflight;
        drive_imem(32'h10, 32'h0, 4'b0);
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0;
        vectors++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL mid_imem_ready got %b want 0", imem_ready); end
        vectors++; if (bram_valid !== 1'b0) begin errors++; $display("FAIL mid_bram_valid got %b want 0", bram_valid); end
        tick();
        vectors++; if (bram_valid !== 1'b0 || imem_ready !== 1'b0) begin errors++; $display("FAIL mid_slots got v%b r%b want 0 0", bram_valid, imem_ready); end
        drive_imem(32'h18, 32'h0, 4'b0);
        tick(); idle();
        tick();
        vectors++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h1111_0006) begin errors++; $display("FAIL mid_next got %b/%h want 1/11110006", imem_ready, imem_rdata); end
        tick();
    endtask

    task automatic test_protocol_violation;
        drive_imem(32'h10, 32'h0, 4'b0);
        tick();
        drive_imem(32'h1C, 32'h0, 4'b0);
        tick(); idle();
        vectors++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h1111_0004) begin errors++; $display("FAIL pv_first got %b/%h want 1/11110004", imem_ready, imem_rdata); end
        vectors++; if (bram_valid !== 1'b0) begin errors++; $display("FAIL pv_dropped_issue got %b want 0", bram_valid); end
        tick();
        vectors++; if (imem_ready !== 1'b0 || bram_valid !== 1'b0) begin errors++; $display("FAIL pv_quiet got r%b v%b want 0 0", imem_ready, bram_valid); end
        tick();
        vectors++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL pv_late got %b want 0", imem_ready); end
    endtask

    initial begin
        rst = 1'b1;
        imem_valid = 1'b0; imem_instr = 1'b0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
        dmem_valid = 1'b0; dmem_instr = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_collision_fair();
        test_fixed_priority();
        test_reset_midflight();
        test_protocol_violation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
